multicycle_sequencer: RTL
=========================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of wait cycles for mem_ready before the ERROR state (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port run  input  1  level request to execute instructions.
REQ-005 SHALL have port op_load  input  1  decoded instruction reads data memory.
REQ-006 SHALL have port op_store  input  1  decoded instruction writes data memory.
REQ-007 SHALL have port op_regwr  input  1  decoded instruction writes the register file.
REQ-008 SHALL have port op_halt  input  1  decoded instruction is HALT.
REQ-009 SHALL have port mem_ready  input  1  data memory access complete this cycle.
REQ-010 SHALL have ports ir_en, pc_en, rf_we, dm_we, mem_req, wb_sel, busy, halted, error, each output 1, plus state output 3.
REQ-011 SHALL have port retired  output  32  retired-instruction count (present only under REQ-030).

Function
REQ-012 SHALL implement the following states: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7; state output = current encoding.
REQ-013 IDLE: run=1 -> FETCH; else stay.
REQ-014 FETCH: ir_en=1 for exactly this cycle; always -> DECODE.
REQ-015 DECODE: latch op_load/op_store/op_regwr/op_halt into internal registers; op_* inputs are ignored outside DECODE; op_halt=1 -> HALT, else -> EXECUTE.
REQ-016 EXECUTE: latched load or store -> MEMORY; else latched regwr -> WRITEBACK; else instruction ends (REQ-020).
REQ-017 MEMORY: mem_req=1 every cycle in state; wait counter clears on entry and increments each cycle mem_ready=0; dm_we=1 only in the cycle mem_ready=1 with latched store.
REQ-018 MEMORY exit: mem_ready=1 with load -> WRITEBACK; mem_ready=1 with store -> instruction ends; wait counter = MEM_TIMEOUT with mem_ready=0 -> ERROR (no dm_we).
REQ-019 WRITEBACK: rf_we=1 for exactly one cycle; wb_sel=latched load (1 = memory data); instruction ends.
REQ-020 Instruction end: pc_en=1 for exactly that cycle; next state FETCH if run=1, IDLE if run=0.
REQ-021 Latched load and store both set: treated as load (no dm_we); store ignored.
REQ-022 run deassertion mid-instruction SHALL NOT abort the instruction; it is sampled only at instruction end.
REQ-023 HALT and ERROR are sticky until reset; halted=1 in HALT; error=1 in ERROR; no enable pulses in either state.
REQ-024 busy=1 in states FETCH..WRITEBACK, 0 otherwise.
REQ-025 All outputs SHALL be decoded from registered state and latched flags only (Moore), except dm_we and the MEMORY-exit pc_en, which also depend on mem_ready.
REQ-026 Minimum latency per instruction: ALU-only no-write 3 cycles, regwr 4, store 4+waits, load 5+waits.

Reset
REQ-027 rst=0 SHALL force state IDLE, clear latched flags and wait counter immediately, independent of clk.
REQ-028 During and after reset, all outputs are 0 (state=0, retired=0) until the first qualifying clk edge with rst=1.
REQ-029 Reset mid-MEMORY SHALL drop mem_req in the same cycle; no dm_we is produced.

Configuration
REQ-030 Macro SEQ_RETIRE_CNT_EN: when defined, retired (32-bit) increments by 1 on every pc_en cycle, wraps 0xFFFFFFFF->0, holds in HALT/ERROR; when undefined, the retired port and counter are absent and the remaining behaviour is identical.

Verification
REQ-031 Reset, then run=1 with ALU op (regwr=1): states 1,2,3,5,1; ir_en cycle 1, rf_we cycle 4, pc_en cycle 4, wb_sel=0.
REQ-032 Load with mem_ready delayed 3 cycles: MEMORY held 4 cycles, mem_req=1 throughout, then WRITEBACK with rf_we=1, wb_sel=1, dm_we never 1.
REQ-033 Store with mem_ready=1 first cycle: dm_we=1 and pc_en=1 in same cycle, rf_we never 1, next state FETCH.
REQ-034 Store with mem_ready tied 0, MEM_TIMEOUT=15: ERROR entered after 15 wait cycles, error=1 sticky, dm_we never 1, until rst=0.
REQ-035 op_halt=1 at DECODE: state 6, halted=1, run toggling has no effect; run=0 during an EXECUTE: instruction completes, then IDLE.
REQ-036 With SEQ_RETIRE_CNT_EN: 10 instructions -> retired=10; assert rst=0 mid-MEMORY -> mem_req=0 and retired=0 immediately.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with sticky HALT and ERROR.
// Optional build macro SEQ_RETIRE_CNT_EN adds the 32-bit retired-instruction counter port.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        op_load,
    input  logic        op_store,
    input  logic        op_regwr,
    input  logic        op_halt,
    input  logic        mem_ready,
    output logic        ir_en,
    output logic        pc_en,
    output logic        rf_we,
    output logic        dm_we,
    output logic        mem_req,
    output logic        wb_sel,
    output logic        busy,
    output logic        halted,
    output logic        error,
    output logic [2:0]  state
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    // Last wait-counter value still allowed; a miss there is the final wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic       ld_q;
    logic       st_q;
    logic       rw_q;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                ld_q <= op_load;
                st_q <= op_store;
                rw_q <= op_regwr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (state_q != S_MEMORY) begin
            wait_cnt <= 8'd0;
        end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Memory handshake: mem_req stays high for the whole MEMORY stay; a cycle with
    // mem_req=1 and mem_ready=1 completes the access, and dm_we is valid only in that cycle.
    always_comb begin
        state_d = state_q;
        ir_en   = 1'b0;
        pc_en   = 1'b0;
        rf_we   = 1'b0;
        dm_we   = 1'b0;
        mem_req = 1'b0;
        wb_sel  = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        error   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                ir_en   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_d = op_halt ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                busy = 1'b1;
                if (ld_q || st_q) begin
                    state_d = S_MEMORY;
                end else if (rw_q) begin
                    state_d = S_WRITEBACK;
                end else begin
                    pc_en   = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEMORY: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    // A load wins when both flags are latched; the store is dropped.
                    if (ld_q) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        dm_we   = 1'b1;
                        pc_en   = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_WRITEBACK: begin
                busy    = 1'b1;
                rf_we   = 1'b1;
                wb_sel  = ld_q;
                pc_en   = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state = state_q;

`ifdef SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= 32'd0;
        end else if (pc_en) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule
